rep_umul_array: RTL and testbench
=================================

// Module: rep_umul_array
// PURPOSE
//  CH-lane unary (rate-coded) multiplier with integrated Sobol stream generation and windowed result counting.
//  Per lane: B operand is registered and converted to a bitstream (B > sobolseq); AND with incoming unary bit A.
//  The product bits are counted over a 2^WIN_LOG2-cycle window; oValid/oProd are handed to the host.
//  Sits between the unary datapath (A streams) and the binary accumulation/readout stage.
// PARAMETERS
//  BITWIDTH  8  width of B operand and of the Sobol sequence
//  CH        4  number of independent multiplier lanes (>=1)
//  WIN_LOG2  8  log2 of window length in enabled cycles (<=BITWIDTH)
// PORTS
//  iClk    in   1               clock, rising edge
//  iRstN   in   1               async active-low reset
//  iLoadB  in   1               capture iB into the lane B registers (IDLE/DONE only)
//  iB      in   CH*BITWIDTH     lane c operand at [c*BITWIDTH +: BITWIDTH]
//  iStart  in   1               begin (or restart) a window
//  iAEn    in   1               A bits valid this cycle; low = stall (no RNG advance, no count)
//  iA      in   CH              unary input bit per lane
//  iAck    in   1               host consumed result; DONE->IDLE
//  oMult   out  CH              registered per-lane product bit
//  oBusy   out  1               high in RUN
//  oValid  out  1               high in DONE
//  oProd   out  CH*(WIN_LOG2+1) per-lane one-count, lane c at [c*(WIN_LOG2+1) +: WIN_LOG2+1]
// BEHAVIOUR
//  - Reset (async, any time incl. mid-window): state IDLE; B regs, counters, window count, Sobol index,
//    oMult, oBusy, oValid, oProd all 0.
//  - FSM IDLE -> RUN on iStart. RUN -> DONE on the edge consuming the 2^WIN_LOG2-th enabled cycle.
//    DONE -> IDLE on iAck. iStart in RUN or DONE restarts: counters and window cleared, Sobol index 0, state RUN.
//    iStart and iAck on the same edge: iStart wins.
//  - iLoadB is honoured in IDLE and DONE; it is ignored in RUN.
//    iLoadB together with iStart: the new B is used from the first RUN cycle.
//  - RUN cycle with iAEn=1:
//      m[c] = iA[c] & (Breg[c] > sobolseq)
//      next edge: oMult <= m; cnt[c] <= cnt[c] + m[c]; Sobol advances; window count +1.
//  - RUN cycle with iAEn=0: oMult <= 0; counters, Sobol and window count hold.
//  - Outside RUN: oMult = 0. Inputs iA/iAEn are ignored.
//  - Latency: oMult is 1 cycle after its A bit. oValid rises the cycle after the last counted bit.
//    oProd equals the final counts while oValid=1 and holds until restart or reset.
//  - Counter width WIN_LOG2+1 holds the full value 2^WIN_LOG2 without wrap; no saturation logic needed.
//  - The Sobol comparison uses the top WIN_LOG2 bits scaled to BITWIDTH; the full sequence is used when
//    WIN_LOG2==BITWIDTH.
//  - A strict '>' compare is used: B=0 gives an all-zero stream, B=2^BITWIDTH-1 gives 2^BITWIDTH-1 ones.
// CONFIGURATION
//  - `REP_UMUL_BIPOLAR_EN defined: m[c] = ~(iA[c] ^ bstream[c]) (XNOR, bipolar multiply).
//    All-ones window count 2^WIN_LOG2 is reachable.
//  - Not defined: unipolar AND as above.
//  - Ports, timing and FSM are identical in both builds.
// STRUCTURE
//  - Package rep_umul_pkg holds:
//      typedef enum logic [1:0] {IDLE, RUN, DONE} umul_state_t;
//      function cnt_w(win) = win+1;
//  - Sub-module umul_lane (one per lane, generate loop): B register, comparator, AND/XNOR,
//    oMult flop, counter.
//  - One shared sobolrng instance, advanced by the top. FSM and window counter are in the top.
// TESTING
//  1. BITWIDTH=8, WIN=8, B=128 all lanes, iA=1 constant, iAEn=1
//     -> oValid after 256 counted cycles, every lane oProd=128.
//  2. Lanes B={0,255,64,192}, iA=1
//     -> oProd={0,255,64,192}. Lanes are independent.
//  3. B=255, iA=1 for first 128 cycles then 0
//     -> oProd=128 (first 128 Sobol points are even).
//  4. B=128, iA=1, iAEn toggled 1/0 every cycle
//     -> oValid after 512 clocks, oProd=128. oMult=0 on stalled cycles.
//  5. iRstN low mid-RUN -> all outputs 0 immediately. New iStart runs a full clean window.
//     Also: iStart issued in DONE -> restart with oValid dropping.
//  6. `REP_UMUL_BIPOLAR_EN defined, B=0, iA=0 -> oProd=256.
//     B=128, iA=1 -> 128. Also: iLoadB during RUN is ignored.

Source files
------------

// File: rtl/rep_umul_pkg.sv
// rep_umul_pkg: shared FSM state type and counter-width helper for rep_umul_array
package rep_umul_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} umul_state_t;
  function automatic int cnt_w(input int win);
    return win + 1;
  endfunction
endpackage

// File: rtl/rep_umul_array_lane.sv
// umul_lane: one unary multiplier lane (B register, B>seq comparator, AND/XNOR, product flop, one-counter)
//  clk, rst_n : clock, async active-low reset
//  load, b    : capture operand b
//  clr        : clear the one-counter
//  en         : counted cycle (product registered and accumulated)
//  a, seq     : unary input bit, shared Sobol point
//  mult, cnt  : registered product bit, window one-count
//  REP_UMUL_BIPOLAR_EN selects XNOR (bipolar) instead of AND (unipolar)
module umul_lane import rep_umul_pkg::*; #(
  parameter int BITWIDTH = 8,
  parameter int WIN_LOG2 = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic                          clr,
  input  logic                          en,
  input  logic                          a,
  input  logic [BITWIDTH-1:0]           b,
  input  logic [BITWIDTH-1:0]           seq,
  output logic                          mult,
  output logic [cnt_w(WIN_LOG2)-1:0]    cnt
);
  localparam int CW = cnt_w(WIN_LOG2);
  logic [BITWIDTH-1:0] b_q;
  logic bs, m;
  assign bs = b_q > seq;
`ifdef REP_UMUL_BIPOLAR_EN
  assign m = ~(a ^ bs);
`else
  assign m = a & bs;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      b_q  <= '0;
      mult <= 1'b0;
      cnt  <= '0;
    end else begin
      if (load) b_q <= b;
      mult <= en & m;
      cnt  <= clr ? '0 : cnt + CW'(en & m);
    end
endmodule

// File: rtl/rep_umul_array_sobolrng.sv
// sobolrng: first-dimension Sobol (van der Corput) source, index bit-reversed into the top WIN_LOG2 bits
//  clk, rst_n : clock, async active-low reset
//  clr        : restart sequence at index 0
//  en         : advance to the next point
//  seq        : current point, BITWIDTH bits
module sobolrng #(
  parameter int BITWIDTH = 8,
  parameter int WIN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  output logic [BITWIDTH-1:0] seq
);
  logic [WIN_LOG2-1:0] idx, rev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idx <= '0;
    else if (clr) idx <= '0;
    else if (en) idx <= idx + 1'b1;
  always_comb begin
    rev = '0;
    for (int i = 0; i < WIN_LOG2; i++) rev[i] = idx[WIN_LOG2-1-i];
  end
  // left-align so the low bits stay zero when the window is shorter than the full sequence
  assign seq = BITWIDTH'(rev) << (BITWIDTH - WIN_LOG2);
endmodule

// File: rtl/rep_umul_array.sv
// rep_umul_array: CH-lane unary multiplier with shared Sobol stream and windowed one-counting
//  iClk, iRstN : clock, async active-low reset
//  iLoadB, iB  : load lane operands (honoured outside RUN), lane c at [c*BITWIDTH +: BITWIDTH]
//  iStart      : begin/restart a window (wins over iAck)
//  iAEn, iA    : unary input bits valid / per-lane bits
//  iAck        : host consumed result, DONE -> IDLE
//  oMult       : registered per-lane product bit
//  oBusy       : RUN, oValid : DONE
//  oProd       : per-lane counts, lane c at [c*(WIN_LOG2+1) +: WIN_LOG2+1]
//  REP_UMUL_BIPOLAR_EN selects bipolar (XNOR) multiplication
module rep_umul_array import rep_umul_pkg::*; #(
  parameter int BITWIDTH = 8,
  parameter int CH       = 4,
  parameter int WIN_LOG2 = 8
) (
  input  logic                         iClk,
  input  logic                         iRstN,
  input  logic                         iLoadB,
  input  logic [CH*BITWIDTH-1:0]       iB,
  input  logic                         iStart,
  input  logic                         iAEn,
  input  logic [CH-1:0]                iA,
  input  logic                         iAck,
  output logic [CH-1:0]                oMult,
  output logic                         oBusy,
  output logic                         oValid,
  output logic [CH*(WIN_LOG2+1)-1:0]   oProd
);
  localparam int CW = cnt_w(WIN_LOG2);
  umul_state_t state_q, state_d;
  logic [WIN_LOG2-1:0] win_q;
  logic [BITWIDTH-1:0] seq;
  logic run, adv;
  assign run = state_q == RUN;
  // a restart edge is not a counted cycle even if iAEn is high
  assign adv = run & iAEn & ~iStart;
  always_comb begin
    state_d = state_q;
    if (iStart) state_d = RUN;
    else if (adv && &win_q) state_d = DONE;
    else if (state_q == DONE && iAck) state_d = IDLE;
  end
  always_ff @(posedge iClk or negedge iRstN)
    if (!iRstN) begin
      state_q <= IDLE;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= iStart ? '0 : adv ? win_q + 1'b1 : win_q;
    end
  assign oBusy  = run;
  assign oValid = state_q == DONE;
  sobolrng #(.BITWIDTH(BITWIDTH), .WIN_LOG2(WIN_LOG2)) u_rng (
    .clk(iClk), .rst_n(iRstN), .clr(iStart), .en(adv), .seq(seq)
  );
  for (genvar c = 0; c < CH; c++) begin : g_lane
    umul_lane #(.BITWIDTH(BITWIDTH), .WIN_LOG2(WIN_LOG2)) u_lane (
      .clk(iClk), .rst_n(iRstN), .load(iLoadB & ~run), .clr(iStart), .en(adv),
      .a(iA[c]), .b(iB[c*BITWIDTH +: BITWIDTH]), .seq(seq),
      .mult(oMult[c]), .cnt(oProd[c*CW +: CW])
    );
  end
endmodule

// File: tb/tb_rep_umul_array.sv
// tb_rep_umul_array: table-driven and randomized self-checking bench for rep_umul_array
module tb_rep_umul_array;
  localparam int BW = 8, CH = 4, WL = 8, CW = WL + 1, N = 1 << WL;
  logic iClk = 1'b0, iRstN = 1'b0, iLoadB = 1'b0, iStart = 1'b0, iAEn = 1'b0, iAck = 1'b0;
  logic [CH*BW-1:0] iB = '0;
  logic [CH-1:0] iA = '0;
  logic [CH-1:0] oMult;
  logic oBusy, oValid;
  logic [CH*CW-1:0] oProd;
  int checks = 0, errors = 0;
  typedef struct {
    logic [CH*BW-1:0] b;
    int am;
    int em;
    int ec;
    logic [CH*CW-1:0] ep;
  } vec_t;
  always #5 iClk = ~iClk;
  rep_umul_array #(.BITWIDTH(BW), .CH(CH), .WIN_LOG2(WL)) dut (
    .iClk(iClk), .iRstN(iRstN), .iLoadB(iLoadB), .iB(iB), .iStart(iStart), .iAEn(iAEn),
    .iA(iA), .iAck(iAck), .oMult(oMult), .oBusy(oBusy), .oValid(oValid), .oProd(oProd)
  );
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge iClk);
    #1;
  endtask
  // k-th Sobol point: bit i of k carries weight 2^(BW-1-i)
  function automatic int sob(input int k);
    int r = 0;
    for (int i = 0; i < WL; i++) if (((k >> i) & 1) == 1) r += 1 << (BW - 1 - i);
    return r;
  endfunction
  function automatic logic mbit(input int b, input logic a, input int k);
    logic bs;
    bs = b > sob(k);
`ifdef REP_UMUL_BIPOLAR_EN
    return ~(a ^ bs);
`else
    return a & bs;
`endif
  endfunction
  // am: 0 all ones, 1 all zeros, 2 ones for first half of counted bits, 3 random
  // em: 0 always enabled, 1 enabled on odd cycles, 2 random
  task automatic run_window(input logic [CH*BW-1:0] b, input int am, input int em, input bit ack,
                            input bit sa, input int gl, input int ab,
                            output int cyc, output logic [CH*CW-1:0] prod);
    int k = 0;
    int cnt[CH];
    logic [CH-1:0] m, a;
    logic e;
    logic [CH*CW-1:0] mp;
    foreach (cnt[c]) cnt[c] = 0;
    cyc = 0;
    prod = '0;
    iB = b; iLoadB = 1'b1; iStart = 1'b1; iAck = sa;
    step();
    iLoadB = 1'b0; iStart = 1'b0; iAck = 1'b0;
    chk("start", {oMult, oBusy, oValid, oProd}, {{CH{1'b0}}, 1'b1, 1'b0, {(CH*CW){1'b0}}});
    while (k < N && cyc < 2000) begin
      e = (em == 0) || (em == 1 && cyc % 2 == 1) || (em == 2 && $urandom_range(1, 0) == 1);
      for (int c = 0; c < CH; c++)
        a[c] = (am == 0) || (am == 2 && k < N / 2) || (am == 3 && $urandom_range(1, 0) == 1);
      iA = a; iAEn = e;
      iLoadB = cyc == gl;
      iB = cyc == gl ? '0 : b;
      step();
      cyc++;
      for (int c = 0; c < CH; c++) m[c] = e & mbit(int'(b[c*BW +: BW]), a[c], k);
      if (e) begin
        for (int c = 0; c < CH; c++) cnt[c] += int'(m[c]);
        k++;
      end
      chk("cycle", {oMult, oBusy, oValid}, {m, k < N, k == N});
      if (cyc == ab) begin
        #2 iRstN = 1'b0;
        #1 chk("async_rst", {oMult, oBusy, oValid, oProd}, 64'd0);
        step();
        iRstN = 1'b1; iAEn = 1'b0; iLoadB = 1'b0;
        return;
      end
    end
    iAEn = 1'b0; iLoadB = 1'b0; iB = b;
    chk("budget", 64'(k), 64'(N));
    for (int c = 0; c < CH; c++) mp[c*CW +: CW] = CW'(cnt[c]);
    chk("prod_model", oProd, mp);
    prod = oProd;
    if (ack) begin
      iAck = 1'b1;
      step();
      iAck = 1'b0;
      chk("ack", {oBusy, oValid, oProd}, {2'b00, mp});
    end
  endtask
  localparam logic [CH*CW-1:0] P128 = {CH{9'd128}};
  localparam logic [CH*BW-1:0] B128 = {CH{8'd128}};
`ifdef REP_UMUL_BIPOLAR_EN
  localparam logic [CH*CW-1:0] PZERO = {CH{9'd256}};
`else
  localparam logic [CH*CW-1:0] PZERO = '0;
`endif
  initial begin
    vec_t t[5];
    int cyc;
    logic [CH*CW-1:0] p;
    t[0] = '{B128, 0, 0, 256, P128};
    t[1] = '{{8'd192, 8'd64, 8'd255, 8'd0}, 0, 0, 256, {9'd192, 9'd64, 9'd255, 9'd0}};
    t[2] = '{{CH{8'd255}}, 2, 0, 256, P128};
    t[3] = '{B128, 0, 1, 512, P128};
    t[4] = '{{CH{8'd0}}, 1, 0, 256, PZERO};
    repeat (2) step();
    chk("reset", {oMult, oBusy, oValid, oProd}, 64'd0);
    iRstN = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      run_window(t[i].b, t[i].am, t[i].em, 1'b1, 1'b0, -1, -1, cyc, p);
      chk("prod_tab", p, t[i].ep);
      chk("cycles", 64'(cyc), 64'(t[i].ec));
    end
    repeat (5) run_window((CH*BW)'($urandom), 3, 2, 1'b1, 1'b0, -1, -1, cyc, p);
    run_window(B128, 0, 0, 1'b1, 1'b0, -1, 60, cyc, p);
    chk("idle_after_rst", {oBusy, oValid, oProd}, 64'd0);
    run_window(B128, 0, 0, 1'b1, 1'b0, -1, -1, cyc, p);
    chk("clean_after_rst", p, P128);
    run_window(t[1].b, 0, 0, 1'b0, 1'b0, -1, -1, cyc, p);
    repeat (3) step();
    chk("done_hold", {oValid, oProd}, {1'b1, t[1].ep});
    run_window(B128, 0, 0, 1'b1, 1'b1, -1, -1, cyc, p);
    chk("restart_done", p, P128);
    run_window(B128, 0, 0, 1'b1, 1'b0, 10, -1, cyc, p);
    chk("load_in_run", p, P128);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
